// File: rtl/uart_tx_fifo_if.sv
// Core-side bundle for the UART transmit FIFO.
// master: the core (drives sdata/tx_ready, observes line and FIFO status).
// slave:  the uart_tx_fifo block.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          sdata;
  logic                tx_ready;
  logic                txd;
  logic                busy;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;

  modport master (
    output sdata, tx_ready,
    input  txd, busy, full, empty, level, overflow
  );

  modport slave (
    input  sdata, tx_ready,
    output txd, busy, full, empty, level, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO.
// Bytes strobed in by the core are queued and sent LSB first as 8N1 frames
// on txd. Back-to-back frames leave no idle gap between stop and next start.
// Optional build macro UART_TX_PARITY_EN: adds an even-parity bit between the
// data bits and the stop bit (8E1 frames, 11 bit times).
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input logic          clk,
  input logic          rstn,
  uart_tx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0]         BAUD_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg;
  logic                  overflow_reg;

  // Serializer state
  state_t                state_reg;
  logic [CW-1:0]         baud_reg;
  logic [2:0]            bit_idx_reg;
  logic [7:0]            shift_reg;
  logic                  txd_reg;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg;
`endif

  logic full;
  logic empty;
  logic baud_last;
  logic push;
  logic pop;
  logic [7:0] head;

  // Status comes only from registers, so tx_ready never reaches full/empty.
  assign full      = (level_reg == LEVEL_FULL);
  assign empty     = (level_reg == '0);
  assign baud_last = (baud_reg == BAUD_LAST);
  // full is judged before any same-edge pop: a write into a full FIFO is
  // always dropped.
  assign push      = bus.tx_ready & ~full;
  assign pop       = ~empty & ((state_reg == IDLE) | ((state_reg == STOP) & baud_last));
  assign head      = mem[rd_ptr_reg];

  assign bus.txd      = txd_reg;
  assign bus.busy     = (state_reg != IDLE) | ~empty;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level_reg;
  assign bus.overflow = overflow_reg;

  // FIFO storage write; contents need no reset since level gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.sdata;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LEVEL_ONE;
        2'b01:   level_reg <= level_reg - LEVEL_ONE;
        default: level_reg <= level_reg;
      endcase
      if (bus.tx_ready && full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Frame serializer: start bit, 8 data bits LSB first, [parity], stop bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      txd_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          txd_reg <= 1'b1;
          if (pop) begin
            shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^head;
`endif
            txd_reg    <= 1'b0;
            baud_reg   <= '0;
            state_reg  <= START;
          end
        end

        START: begin
          if (baud_last) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            txd_reg     <= shift_reg[0];
            state_reg   <= DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd_reg   <= parity_reg;
              state_reg <= PARITY;
`else
              txd_reg   <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              txd_reg     <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_reg  <= '0;
            txd_reg   <= 1'b1;
            state_reg <= STOP;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (pop) begin
              // Next byte already waiting: start bit follows with no gap.
              shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
              parity_reg <= ^head;
`endif
              txd_reg    <= 1'b0;
              state_reg  <= START;
            end else begin
              txd_reg   <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        default: begin
          txd_reg   <= 1'b1;
          baud_reg  <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (CLK_PER_BIT=4, DEPTH_LOG2=2).
// Reference model: a byte queue plus a frame timer; the expected line level
// is looked up from the frame's bit list using elapsed time / CLK_PER_BIT.
// Build with +define+UART_TX_PARITY_EN to exercise 8E1 frames.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_LEN = NBITS * CPB;

  logic clk;
  logic rstn;

  uart_tx_fifo_if #(.DEPTH_LOG2(DL2)) bus_if ();

  uart_tx_fifo #(
    .CLK_PER_BIT(CPB),
    .DEPTH_LOG2 (DL2)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0]       q[$];
  bit               m_active;
  int               m_elapsed;
  logic [NBITS-1:0] m_frame;
  bit               m_ovf;

  // Activity measurement: cycles with busy high since the first start bit
  bit act_started;
  int act_cnt;
  int peak_level;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active  = 1'b0;
    m_elapsed = 0;
    m_frame   = '1;
    m_ovf     = 1'b0;
  endtask

  task automatic model_start(input logic [7:0] d);
    m_active  = 1'b1;
    m_elapsed = 0;
    m_frame   = '1;
    m_frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_frame[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    m_frame[9] = ^d;
`endif
  endtask

  // One clock edge of the reference model, applied to the inputs seen at it.
  task automatic model_edge(input bit wr, input logic [7:0] d);
    bit full_before;
    full_before = (q.size() == DEPTH);
    if (m_active) begin
      if (m_elapsed == FRAME_LEN - 1) begin
        if (q.size() > 0) model_start(q.pop_front());
        else m_active = 1'b0;
      end else begin
        m_elapsed++;
      end
    end else if (q.size() > 0) begin
      model_start(q.pop_front());
    end
    if (wr) begin
      if (full_before) m_ovf = 1'b1;
      else q.push_back(d);
    end
  endtask

  task automatic compare_all();
    logic exp_txd;
    exp_txd = m_active ? m_frame[m_elapsed / CPB] : 1'b1;
    check("txd",      bus_if.txd,      exp_txd);
    check("busy",     bus_if.busy,     m_active || (q.size() > 0));
    check("level",    bus_if.level,    q.size());
    check("full",     bus_if.full,     q.size() == DEPTH);
    check("empty",    bus_if.empty,    q.size() == 0);
    check("overflow", bus_if.overflow, m_ovf);
  endtask

  task automatic step(input bit wr, input logic [7:0] d);
    bus_if.tx_ready = wr;
    bus_if.sdata    = d;
    @(posedge clk);
    model_edge(wr, d);
    #1;
    bus_if.tx_ready = 1'b0;
    compare_all();
    if (bus_if.txd == 1'b0) act_started = 1'b1;
    if (act_started && bus_if.busy) act_cnt++;
    if (int'(bus_if.level) > peak_level) peak_level = int'(bus_if.level);
    if (wr) $display("wr %02h level=%0d overflow=%0d", d, bus_if.level, bus_if.overflow);
  endtask

  task automatic clear_meas();
    act_started = 1'b0;
    act_cnt     = 0;
    peak_level  = 0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      step(1'b0, 8'h00);
      if (!bus_if.busy && !m_active && q.size() == 0) done = 1'b1;
    end
    check("drain_timeout", done, 1'b1);
  endtask

  task automatic wait_elapsed(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      if (m_active && m_elapsed == target) hit = 1'b1;
      else step(1'b0, 8'h00);
    end
    check("wait_timeout", hit, 1'b1);
  endtask

  // Assert reset between clock edges and confirm the line releases at once.
  task automatic async_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    check({tag, "_txd"},   bus_if.txd,   1'b1);
    check({tag, "_busy"},  bus_if.busy,  1'b0);
    check({tag, "_level"}, bus_if.level, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check({tag, "_empty"}, bus_if.empty,    1'b1);
    check({tag, "_ovf"},   bus_if.overflow, 1'b0);
  endtask

  initial begin
    bus_if.tx_ready = 1'b0;
    bus_if.sdata    = 8'h00;
    rstn = 1'b0;
    model_reset();
    clear_meas();
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd",   bus_if.txd,      1'b1);
    check("rst_busy",  bus_if.busy,     1'b0);
    check("rst_full",  bus_if.full,     1'b0);
    check("rst_empty", bus_if.empty,    1'b1);
    check("rst_level", bus_if.level,    0);
    check("rst_ovf",   bus_if.overflow, 1'b0);
    rstn = 1'b1;
    repeat (3) step(1'b0, 8'h00);

    // Single byte: start bit one cycle after the write edge, one frame long.
    clear_meas();
    step(1'b1, 8'h55);
    check("t1_txd_before", bus_if.txd, 1'b1);
    step(1'b0, 8'h00);
    check("t1_txd_start", bus_if.txd, 1'b0);
    drain();
    check("t1_active", act_cnt, FRAME_LEN);
    check("t1_empty", bus_if.empty, 1'b1);

    // Three consecutive writes: first popped at once, frames back to back.
    clear_meas();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    step(1'b1, 8'hFF);
    drain();
    check("t2_peak", peak_level, 2);
    check("t2_active", act_cnt, 3 * FRAME_LEN);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0 (line checked by model).
    clear_meas();
    step(1'b1, 8'h07);
    drain();
    check("t6_len", act_cnt, 11 * CPB);
    clear_meas();
    step(1'b1, 8'h03);
    wait_elapsed(9 * CPB + 1);
    check("t6_parity0", bus_if.txd, 1'b0);
    drain();
`endif

    // Overflow: six writes into a 4-deep FIFO while the first frame runs.
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    check("t3_full", bus_if.full, 1'b1);
    check("t3_ovf", bus_if.overflow, 1'b1);

    // Write while full on the edge the stop bit ends: dropped, level drops.
    wait_elapsed(FRAME_LEN - 1);
    step(1'b1, 8'h77);
    check("t4_level", bus_if.level, DEPTH - 1);
    check("t4_ovf", bus_if.overflow, 1'b1);
    drain();
    check("t3_ovf_sticky", bus_if.overflow, 1'b1);

    // Reset during data bit 3 of 0x0F with two bytes queued.
    step(1'b1, 8'h0F);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    wait_elapsed(4 * CPB + 1);
    async_reset("t5");
    repeat (2 * FRAME_LEN) step(1'b0, 8'h00);
    check("t5_idle_txd", bus_if.txd, 1'b1);

    // Reset while the start bit is driving the line low.
    step(1'b1, 8'h00);
    wait_elapsed(1);
    check("t5b_low", bus_if.txd, 1'b0);
    async_reset("t5b");
    repeat (5) step(1'b0, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 11) == 0), 8'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
